// File: rtl/mem_pkg.sv
// Purpose : shared types, transfer-size codes and byte-enable helper for the data memory responder.
// Latency : n/a (declarations only).
// Backpr. : n/a.
package mem_pkg;

   localparam logic [3:0] XFER_B = 4'd1;
   localparam logic [3:0] XFER_H = 4'd2;
   localparam logic [3:0] XFER_W = 4'd4;
   localparam logic [3:0] XFER_D = 4'd8;

   typedef enum logic [1:0] {IDLE, WAIT, DONE} mem_state_t;

   // Byte-enable for an access of the given size, anchored at byte lane 0.
   // Unsupported sizes return no lanes.
   function automatic logic [7:0] size_mask(input logic [3:0] xfer_size);
      logic [7:0] m;
      case (xfer_size)
         XFER_B:  m = 8'h01;
         XFER_H:  m = 8'h03;
         XFER_W:  m = 8'h0F;
         XFER_D:  m = 8'hFF;
         default: m = 8'h00;
      endcase
      return m;
   endfunction

endpackage

// File: rtl/data_mem_responder_if.sv
// Purpose : MEM-stage data request bus between the CPU pipeline and the data memory.
// Latency : n/a (wiring only).
// Backpr. : stall from the memory side holds the requester; done/err end a request.
// Ports   : address/write_data/MemWrite/read_enable/xfer_size (request),
//           read_data/done/stall/err (response).
interface data_mem_responder_if;
   logic [63:0] address;
   logic [63:0] write_data;
   logic        MemWrite;
   logic        read_enable;
   logic [3:0]  xfer_size;
   logic [63:0] read_data;
   logic        done;
   logic        stall;
   logic        err;

   modport master (
      output address, write_data, MemWrite, read_enable, xfer_size,
      input  read_data, done, stall, err
   );

   modport slave (
      input  address, write_data, MemWrite, read_enable, xfer_size,
      output read_data, done, stall, err
   );
endinterface

// File: rtl/byte_lane_ram.sv
// Purpose : byte-addressable little-endian storage built from eight byte-wide lanes.
// Latency : writes commit on the clock edge; reads are combinational.
// Backpr. : none; caller sequences accesses.
// Ports   : clk, we, addr (byte address), byte_en (size mask at lane 0),
//           wdata (data at byte 0), rdata (row rotated so addr byte is at bits 7:0).
module byte_lane_ram #(
   parameter int DEPTH_BYTES = 1024
) (
   input  logic                           clk,
   input  logic                           we,
   input  logic [$clog2(DEPTH_BYTES)-1:0] addr,
   input  logic [7:0]                     byte_en,
   input  logic [63:0]                    wdata,
   output logic [63:0]                    rdata
);

   localparam int AW   = $clog2(DEPTH_BYTES);
   localparam int ROWS = DEPTH_BYTES / 8;
   localparam int RW   = (AW > 3) ? AW - 3 : 1;

   logic [RW-1:0] row;
   logic [2:0]    off;
   logic [63:0]   lane_rd;
   logic [63:0]   wdata_rot;
   logic [7:0]    be_rot;
   logic [2:0]    wsel [8];
   logic [2:0]    rsel [8];

   generate
      if (AW > 3) begin : g_row
         assign row = addr[AW-1:3];
      end else begin : g_row0
         assign row = '0;
      end
   endgenerate

   assign off = addr[2:0];

   // Rotate the request so byte 0 lands on lane 'off'; results truncate to
   // 3 bits so the lane index wraps modulo 8.
   always_comb begin
      for (int i = 0; i < 8; i++) begin
         wsel[i] = 3'(i) - off;
         rsel[i] = 3'(i) + off;
      end
      for (int i = 0; i < 8; i++) begin
         wdata_rot[i*8 +: 8] = wdata[{wsel[i], 3'b000} +: 8];
         be_rot[i]           = byte_en[wsel[i]];
         rdata[i*8 +: 8]     = lane_rd[{rsel[i], 3'b000} +: 8];
      end
   end

   for (genvar g = 0; g < 8; g++) begin : g_lane
      logic [7:0] mem [ROWS];

      always_ff @(posedge clk) begin
         if (we && be_rot[g]) begin
            mem[row] <= wdata_rot[g*8 +: 8];
         end
      end

      assign lane_rd[g*8 +: 8] = mem[row];
   end

endmodule

// File: rtl/data_mem_responder.sv
// Purpose : MEM-stage data memory responder: legality check, fixed-latency FSM, zero-extended loads.
// Latency : request accepted in cycle k completes with a one-cycle done in cycle k+LATENCY.
// Backpr. : stall is held for a legal request until its done cycle; illegal requests never stall and pulse err.
// Ports   : clk, reset (sync, active-high), bus (slave side of data_mem_responder_if).
module data_mem_responder
   import mem_pkg::*;
#(
   parameter int DEPTH_BYTES = 1024,
   parameter int LATENCY     = 2
) (
   input  logic                 clk,
   input  logic                 reset,
   data_mem_responder_if.slave  bus
);

   localparam int AW = $clog2(DEPTH_BYTES);

   mem_state_t    state;
   logic [3:0]    cnt;
   logic [AW-1:0] cap_addr;
   logic [63:0]   cap_data;
   logic          cap_write;
   logic [3:0]    cap_size;
   logic [63:0]   read_data_q;
   logic          done_q;
   logic          err_q;

   logic          req;
   logic          size_ok;
   logic [3:0]    size_m1;
   logic          aligned;
   logic [AW:0]   end_addr;
   logic          in_range;
   logic          legal;
   logic          err_pending;
   logic          accept;
   logic          commit;

   logic [AW-1:0] ram_addr;
   logic [63:0]   ram_wdata;
   logic          ram_write;
   logic [3:0]    ram_size;
   logic [7:0]    ram_be;
   logic          ram_we;
   logic [63:0]   ram_rdata;
   logic [63:0]   load_val;

   always_comb begin
      req      = bus.MemWrite | bus.read_enable;
      size_ok  = (bus.xfer_size == XFER_B) || (bus.xfer_size == XFER_H) ||
                 (bus.xfer_size == XFER_W) || (bus.xfer_size == XFER_D);
      size_m1  = bus.xfer_size - 4'd1;
      aligned  = (bus.address[3:0] & size_m1) == 4'd0;
      end_addr = {1'b0, bus.address[AW-1:0]} + (AW+1)'(bus.xfer_size);
      in_range = (bus.address[63:AW] == '0) && (end_addr <= (AW+1)'(DEPTH_BYTES));
      legal    = (bus.MemWrite ^ bus.read_enable) && size_ok && aligned && in_range;

      err_pending = (state == IDLE) && req && !legal;
      accept      = (state == IDLE) && req && legal;
      // The edge that enters DONE is where memory is actually touched.
      commit      = (accept && (LATENCY == 1)) || ((state == WAIT) && (cnt == 4'd0));
   end

   // With LATENCY==1 the access commits on the accept edge, before anything is
   // captured, so the live bus is used while in IDLE.
   always_comb begin
      if (state == IDLE) begin
         ram_addr  = bus.address[AW-1:0];
         ram_wdata = bus.write_data;
         ram_write = bus.MemWrite;
         ram_size  = bus.xfer_size;
      end else begin
         ram_addr  = cap_addr;
         ram_wdata = cap_data;
         ram_write = cap_write;
         ram_size  = cap_size;
      end
      ram_be = size_mask(ram_size);
      // A reset on the commit edge must not leave a write behind.
      ram_we = commit && ram_write && !reset;
      for (int i = 0; i < 8; i++) begin
         load_val[i*8 +: 8] = ram_be[i] ? ram_rdata[i*8 +: 8] : 8'h00;
      end
   end

   byte_lane_ram #(
      .DEPTH_BYTES(DEPTH_BYTES)
   ) u_ram (
      .clk     (clk),
      .we      (ram_we),
      .addr    (ram_addr),
      .byte_en (ram_be),
      .wdata   (ram_wdata),
      .rdata   (ram_rdata)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= IDLE;
         cnt         <= 4'd0;
         done_q      <= 1'b0;
         err_q       <= 1'b0;
         read_data_q <= 64'd0;
         cap_addr    <= '0;
         cap_data    <= 64'd0;
         cap_write   <= 1'b0;
         cap_size    <= 4'd0;
      end else begin
         done_q <= 1'b0;
         err_q  <= 1'b0;
         case (state)
            IDLE: begin
               if (accept) begin
                  cap_addr  <= bus.address[AW-1:0];
                  cap_data  <= bus.write_data;
                  cap_write <= bus.MemWrite;
                  cap_size  <= bus.xfer_size;
                  if (LATENCY == 1) begin
                     state  <= DONE;
                     done_q <= 1'b1;
                     if (!bus.MemWrite) begin
                        read_data_q <= load_val;
                     end
                  end else begin
                     state <= WAIT;
                     cnt   <= 4'(LATENCY - 2);
                  end
               end else if (err_pending) begin
                  err_q <= 1'b1;
               end
            end
            WAIT: begin
               if (cnt == 4'd0) begin
                  state  <= DONE;
                  done_q <= 1'b1;
                  if (!cap_write) begin
                     read_data_q <= load_val;
                  end
               end else begin
                  cnt <= cnt - 4'd1;
               end
            end
            DONE: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   assign bus.read_data = read_data_q;
   assign bus.done      = done_q;
   assign bus.err       = err_q;
   assign bus.stall     = req & ~done_q & ~err_pending;

endmodule
